pipeline_exe_muldiv: RTL and testbench

//  EXE-stage RV32M unit plus EXE->MEM pipeline register; its registered outputs feed the MEM stage directly.
//  Non-M instructions: combinational ALU result from the same stage plus sideband fields register through in 1 cycle.
//  M-extension ops: iterative radix-2 shift-add multiply / restoring divide, fixed latency.

---
 rtl/pipeline_exe_muldiv.sv | 216 +++++++++++++++++++++
 tb/tb_pipeline_exe_muldiv.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_exe_muldiv.sv
// EXE-stage RV32M multiply/divide unit with the EXE->MEM pipeline register.
// Non-M ops pass through in one cycle; M ops iterate one bit per cycle while stalling IF/ID.

`ifndef DMEM_NO
`define DMEM_NO 4'b1111
`endif

module pipeline_exe_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            valid_d_i,
  input  logic            muldiv_en_d_i,
  input  logic [2:0]      muldiv_op_d_i,
  input  logic [XLEN-1:0] rs1_d_i,
  input  logic [XLEN-1:0] rs2_d_i,
  input  logic [XLEN-1:0] alu_result_d_i,
  input  logic [31:0]     store_data_d_i,
  input  logic [3:0]      dmem_type_d_i,
  input  logic [31:0]     extended_imm_d_i,
  input  logic [31:0]     pc_plus_d_i,
  input  logic            reg_write_en_d_i,
  input  logic [4:0]      rd_idx_d_i,
  input  logic [3:0]      result_src_d_i,
  output logic            stall_e_o,
  output logic [XLEN-1:0] alu_result_e_o,
  output logic [31:0]     store_data_e_o,
  output logic [3:0]      dmem_type_e_o,
  output logic [31:0]     extended_imm_e_o,
  output logic [31:0]     pc_plus_e_o,
  output logic            reg_write_en_e_o,
  output logic [4:0]      rd_idx_e_o,
  output logic [3:0]      result_src_e_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic            start, step, take_input, take_result;

  logic [2:0]      op_q;
  logic [XLEN-1:0] a_mag_q, b_mag_q, rs1_q, hi_q, lo_q;
  logic            a_neg_q, neg_res_q, div_zero_q, ovf_q;

  logic [31:0]     store_data_q, extended_imm_q, pc_plus_q;
  logic [3:0]      dmem_type_q, result_src_q;
  logic            reg_write_en_q;
  logic [4:0]      rd_idx_q;

  logic            a_signed, b_signed, a_neg, b_neg, is_div;
  logic [XLEN:0]   mul_sum, div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, md_result;

  always_comb begin
    next_state  = state;
    stall_e_o   = 1'b0;
    start       = 1'b0;
    step        = 1'b0;
    take_input  = 1'b0;
    take_result = 1'b0;
    case (state)
      IDLE: begin
        if (valid_d_i && !flush_i) begin
          if (muldiv_en_d_i) begin
            start      = 1'b1;
            stall_e_o  = 1'b1;
            next_state = CALC;
          end else begin
            take_input = 1'b1;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          next_state = IDLE;
        end else begin
          stall_e_o = 1'b1;
          step      = 1'b1;
          if (cnt == LAST_CNT) next_state = DONE;
        end
      end
      DONE: begin
        next_state  = IDLE;
        take_result = !flush_i;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= start ? '0 : (step ? cnt + 1'b1 : cnt);
    end
  end

  always_comb begin
    a_signed = (muldiv_op_d_i == OP_MUL) || (muldiv_op_d_i == OP_MULH) ||
               (muldiv_op_d_i == OP_MULHSU) || (muldiv_op_d_i == OP_DIV) ||
               (muldiv_op_d_i == OP_REM);
    b_signed = (muldiv_op_d_i == OP_MUL) || (muldiv_op_d_i == OP_MULH) ||
               (muldiv_op_d_i == OP_DIV) || (muldiv_op_d_i == OP_REM);
    a_neg    = a_signed && rs1_d_i[XLEN-1];
    b_neg    = b_signed && rs2_d_i[XLEN-1];
    is_div   = muldiv_op_d_i[2];
  end

  // Multiply: {hi,lo} shifts right, lo starts as the multiplier.
  // Divide: lo shifts left carrying the dividend in and quotient bits out, hi holds the partial remainder.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : '0);
    div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, b_mag_q};
  end

  always_ff @(posedge clk) begin
    if (start) begin
      op_q       <= muldiv_op_d_i;
      a_mag_q    <= a_neg ? -rs1_d_i : rs1_d_i;
      b_mag_q    <= b_neg ? -rs2_d_i : rs2_d_i;
      rs1_q      <= rs1_d_i;
      a_neg_q    <= a_neg;
      neg_res_q  <= a_neg ^ b_neg;
      div_zero_q <= is_div && (rs2_d_i == '0);
      ovf_q      <= ((muldiv_op_d_i == OP_DIV) || (muldiv_op_d_i == OP_REM)) &&
                    (rs1_d_i == MIN_INT) && (rs2_d_i == '1);
      hi_q       <= '0;
      lo_q       <= is_div ? (a_neg ? -rs1_d_i : rs1_d_i) : (b_neg ? -rs2_d_i : rs2_d_i);

      store_data_q   <= store_data_d_i;
      dmem_type_q    <= dmem_type_d_i;
      extended_imm_q <= extended_imm_d_i;
      pc_plus_q      <= pc_plus_d_i;
      reg_write_en_q <= reg_write_en_d_i;
      rd_idx_q       <= rd_idx_d_i;
      result_src_q   <= result_src_d_i;
    end else if (step) begin
      if (!op_q[2]) begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end else if (!div_trial[XLEN]) begin
        hi_q <= div_trial[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_q <= {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_q <= {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Divide-by-zero and signed overflow override the normal sign fixup.
  always_comb begin
    prod_fix = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = neg_res_q ? -lo_q : lo_q;
    rem_fix  = a_neg_q ? -hi_q : hi_q;
    if (div_zero_q) begin
      quo_fix = '1;
      rem_fix = rs1_q;
    end else if (ovf_q) begin
      quo_fix = MIN_INT;
      rem_fix = '0;
    end
    if (op_q[2])
      md_result = op_q[1] ? rem_fix : quo_fix;
    else
      md_result = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset || !(take_input || take_result)) begin
      alu_result_e_o   <= '0;
      store_data_e_o   <= '0;
      dmem_type_e_o    <= `DMEM_NO;
      extended_imm_e_o <= '0;
      pc_plus_e_o      <= '0;
      reg_write_en_e_o <= 1'b0;
      rd_idx_e_o       <= '0;
      result_src_e_o   <= '0;
    end else if (take_result) begin
      alu_result_e_o   <= md_result;
      store_data_e_o   <= store_data_q;
      dmem_type_e_o    <= dmem_type_q;
      extended_imm_e_o <= extended_imm_q;
      pc_plus_e_o      <= pc_plus_q;
      reg_write_en_e_o <= reg_write_en_q;
      rd_idx_e_o       <= rd_idx_q;
      result_src_e_o   <= result_src_q;
    end else begin
      alu_result_e_o   <= alu_result_d_i;
      store_data_e_o   <= store_data_d_i;
      dmem_type_e_o    <= dmem_type_d_i;
      extended_imm_e_o <= extended_imm_d_i;
      pc_plus_e_o      <= pc_plus_d_i;
      reg_write_en_e_o <= reg_write_en_d_i;
      rd_idx_e_o       <= rd_idx_d_i;
      result_src_e_o   <= result_src_d_i;
    end
  end

endmodule

// File: tb/tb_pipeline_exe_muldiv.sv
// Directed bench for pipeline_exe_muldiv: ALU pass-through, every M-op class,
// divide corner cases, flush and reset during an iteration.

`ifndef DMEM_NO
`define DMEM_NO 4'b1111
`endif

module tb_pipeline_exe_muldiv;

  logic        clk, reset, flush_i, valid_d_i, muldiv_en_d_i;
  logic [2:0]  muldiv_op_d_i;
  logic [31:0] rs1_d_i, rs2_d_i, alu_result_d_i, store_data_d_i, extended_imm_d_i, pc_plus_d_i;
  logic [3:0]  dmem_type_d_i, result_src_d_i;
  logic        reg_write_en_d_i;
  logic [4:0]  rd_idx_d_i;
  logic        stall_e_o;
  logic [31:0] alu_result_e_o, store_data_e_o, extended_imm_e_o, pc_plus_e_o;
  logic [3:0]  dmem_type_e_o, result_src_e_o;
  logic        reg_write_en_e_o;
  logic [4:0]  rd_idx_e_o;

  int total = 0;
  int bad   = 0;

  pipeline_exe_muldiv #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_d_i(valid_d_i),
    .muldiv_en_d_i(muldiv_en_d_i), .muldiv_op_d_i(muldiv_op_d_i),
    .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .alu_result_d_i(alu_result_d_i),
    .store_data_d_i(store_data_d_i), .dmem_type_d_i(dmem_type_d_i),
    .extended_imm_d_i(extended_imm_d_i), .pc_plus_d_i(pc_plus_d_i),
    .reg_write_en_d_i(reg_write_en_d_i), .rd_idx_d_i(rd_idx_d_i),
    .result_src_d_i(result_src_d_i), .stall_e_o(stall_e_o),
    .alu_result_e_o(alu_result_e_o), .store_data_e_o(store_data_e_o),
    .dmem_type_e_o(dmem_type_e_o), .extended_imm_e_o(extended_imm_e_o),
    .pc_plus_e_o(pc_plus_e_o), .reg_write_en_e_o(reg_write_en_e_o),
    .rd_idx_e_o(rd_idx_e_o), .result_src_e_o(result_src_e_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sidebands are derived from the ALU value so their registered copies can be predicted.
  task automatic applyStimulus(input logic v, input logic en, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] alu, input logic [4:0] rd);
    valid_d_i        = v;
    muldiv_en_d_i    = en;
    muldiv_op_d_i    = op;
    rs1_d_i          = a;
    rs2_d_i          = b;
    alu_result_d_i   = alu;
    store_data_d_i   = v ? (alu ^ 32'hFFFF_0000) : 32'h0;
    dmem_type_d_i    = v ? 4'b0010 : `DMEM_NO;
    extended_imm_d_i = v ? 32'h0000_0123 : 32'h0;
    pc_plus_d_i      = v ? (alu + 32'd4) : 32'h0;
    reg_write_en_d_i = v;
    rd_idx_d_i       = rd;
    result_src_d_i   = v ? 4'b0001 : 4'b0000;
  endtask

  // Presents an M-op and holds it until the result reaches MEM, returning right after that edge.
  task automatic runMop(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int edges;
    int stalls;
    bit got;
    edges = 0; stalls = 0; got = 1'b0;
    applyStimulus(1'b1, 1'b1, op, a, b, 32'hDEAD_BEEF, rd);
    while (!got && edges < 60) begin
      #1;
      if (stall_e_o) stalls++;
      @(posedge clk); #1;
      edges++;
      if (reg_write_en_e_o) got = 1'b1;
    end
    checkOutput({tag, "_latency"}, edges, 34);
    checkOutput({tag, "_stall"}, stalls, 33);
    checkOutput({tag, "_result"}, alu_result_e_o, exp);
    checkOutput({tag, "_rd"}, rd_idx_e_o, rd);
  endtask

  initial begin
    reset   = 1'b1;
    flush_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_alu", alu_result_e_o, 32'h0);
    checkOutput("rst_dmem", dmem_type_e_o, `DMEM_NO);
    checkOutput("rst_we", reg_write_en_e_o, 1'b0);
    checkOutput("rst_stall", stall_e_o, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_0100 + i, 5'(i + 1));
      #1;
      checkOutput("add_stall", stall_e_o, 1'b0);
      @(posedge clk); #1;
      checkOutput("add_result", alu_result_e_o, 32'h0000_0100 + i);
      checkOutput("add_rd", rd_idx_e_o, i + 1);
    end
    checkOutput("add_store", store_data_e_o, 32'hFFFF_0103);
    checkOutput("add_pcplus", pc_plus_e_o, 32'h0000_0107);
    checkOutput("add_dmem", dmem_type_e_o, 4'b0010);

    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd9);
    @(posedge clk); #1;
    checkOutput("bubble_we", reg_write_en_e_o, 1'b0);
    checkOutput("bubble_dmem", dmem_type_e_o, `DMEM_NO);

    runMop("mul",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    runMop("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
    runMop("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
    runMop("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF);
    runMop("div",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD);
    runMop("rem",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF);
    runMop("divu",   3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'h7FFF_FFFC);
    runMop("div0",   3'd4, 32'h0000_0005, 32'h0000_0000, 5'd13, 32'hFFFF_FFFF);
    runMop("rem0",   3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 5'd14, 32'hFFFF_FFFB);
    runMop("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    runMop("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000);

    // Flush while the divider is in its tenth iteration cycle.
    applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_0064, 32'h0000_0007, 32'h0, 5'd17);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("flush_pre_stall", stall_e_o, 1'b1);
    flush_i = 1'b1;
    #1;
    checkOutput("flush_stall", stall_e_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    checkOutput("flush_we", reg_write_en_e_o, 1'b0);
    checkOutput("flush_dmem", dmem_type_e_o, `DMEM_NO);
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_0777, 5'd18);
    #1;
    checkOutput("post_flush_stall", stall_e_o, 1'b0);
    @(posedge clk); #1;
    checkOutput("post_flush_add", alu_result_e_o, 32'h0000_0777);
    checkOutput("post_flush_we", reg_write_en_e_o, 1'b1);

    // Reset in the middle of a multiply.
    applyStimulus(1'b1, 1'b1, 3'd0, 32'h0000_0003, 32'h0000_0005, 32'h0, 5'd19);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midrst_alu", alu_result_e_o, 32'h0);
    checkOutput("midrst_dmem", dmem_type_e_o, `DMEM_NO);
    checkOutput("midrst_we", reg_write_en_e_o, 1'b0);
    checkOutput("midrst_rd", rd_idx_e_o, 5'd0);
    checkOutput("midrst_stall", stall_e_o, 1'b0);

    runMop("mul_after_rst", 3'd0, 32'h0000_0003, 32'h0000_0005, 5'd20, 32'h0000_000F);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
